traffic_lights_cmd_master: RTL and testbench
============================================

TRAFFIC_LIGHTS_CMD_MASTER -- requirements
Module: traffic_lights_cmd_master

Interface
REQ-001 Parameter CMD_GAP, default 1: idle cycles between consecutive cmd_valid_o pulses; legal range 0..255.
REQ-002 Parameter DATA_W, default 16: width of period fields and cmd_data_o.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 cfg_valid_i  input  1  host request valid.
REQ-006 cfg_ready_o  output  1  block can accept a request.
REQ-007 cfg_op_i  input  2  request opcode: 0 RECONFIG, 1 OFF, 2 ON, 3 reserved.
REQ-008 cfg_red_i, cfg_yellow_i, cfg_green_i  input  DATA_W each  requested periods in clock cycles.
REQ-009 cmd_type_o  output  3  command code: ON=0, OFF=1, TO_NOTRANSITION=2, GREEN_SET=3, RED_SET=4, YELLOW_SET=5.
REQ-010 cmd_valid_o  output  1  one-cycle command strobe; the consumer has no ready signal.
REQ-011 cmd_data_o  output  DATA_W  command payload.
REQ-012 busy_o  output  1  sequence in progress.
REQ-013 err_o  output  1  one-cycle pulse for a rejected request.

Function
REQ-014 A request SHALL be accepted on a cycle where cfg_valid_i && cfg_ready_o; cfg_op_i and all three period fields SHALL be captured on that edge.
REQ-015 cfg_ready_o SHALL be 1 only in state IDLE; busy_o SHALL equal !cfg_ready_o.
REQ-016 States SHALL be IDLE, S_NOTR, S_GREEN, S_RED, S_YELLOW, S_ON, S_OFF, GAP.
REQ-017 Each S_* state SHALL last exactly one cycle, with cmd_valid_o=1 and the matching cmd_type_o.
REQ-018 The RECONFIG sequence SHALL be TO_NOTRANSITION (data 0), GREEN_SET (green), RED_SET (red), YELLOW_SET (yellow), ON (data 0).
REQ-019 The OFF opcode SHALL issue a single OFF command (data 0); the ON opcode SHALL issue a single ON command (data 0).
REQ-020 The first command of a sequence SHALL be driven in the cycle after acceptance (latency 1).
REQ-021 After every command, including the last, the FSM SHALL spend exactly CMD_GAP cycles in GAP, then go to the next S_* state or to IDLE.
REQ-022 With CMD_GAP=0, GAP SHALL be skipped and commands SHALL issue on consecutive cycles.
REQ-023 The gap counter SHALL be 8 bits, load CMD_GAP-1 on entry to GAP, decrement to 0, and never wrap.
REQ-024 If a RECONFIG request has any period field equal to 0, it SHALL be accepted, no command SHALL be issued, err_o SHALL pulse 1 in the next cycle, and the FSM SHALL stay in IDLE.
REQ-025 Opcode 3 SHALL be handled like REQ-024: accepted, err_o pulse, no command.
REQ-026 While busy_o=1, cfg_valid_i SHALL be ignored; the request is neither queued nor dropped, because cfg_ready_o=0.
REQ-027 While cmd_valid_o=0, cmd_type_o SHALL be 0 and cmd_data_o SHALL be 0.
REQ-028 Captured periods SHALL be held unchanged until the sequence ends, regardless of the input fields.

Reset
REQ-029 Asserting rst_n_i=0 SHALL immediately force IDLE, cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, err_o=0, busy_o=0, cfg_ready_o=0, gap counter=0, and captured periods=0.
REQ-030 During reset, cfg_ready_o SHALL be 0; it SHALL become 1 on the first posedge after rst_n_i deasserts.
REQ-031 A reset in the middle of a sequence SHALL abort it; no further commands from that sequence SHALL be issued.

Verification
REQ-032 CMD_GAP=1, RECONFIG red=20 yellow=6 green=15, accepted at cycle T -> cmd_valid_o at T+1/3/5/7/9 with (2,0), (3,15), (4,20), (5,6), (0,0); cfg_ready_o=1 at T+11.
REQ-033 CMD_GAP=0, same request -> five consecutive strobes at T+1..T+5; IDLE at T+6.
REQ-034 RECONFIG with yellow=0 -> no cmd_valid_o; err_o=1 at T+1 only; cfg_ready_o stays 1.
REQ-035 OFF accepted, then cfg_valid_i held high with ON during busy -> exactly one OFF strobe; ON accepted only once cfg_ready_o returns, giving one ON strobe.
REQ-036 rst_n_i pulsed low at T+4 of the REQ-032 sequence -> cmd_valid_o=0 asynchronously; no further strobes; cfg_ready_o=1 on the first posedge after release.

Source files
------------

// File: rtl/traffic_lights_cmd_master.sv
// -----------------------------------------------------------------------------
// traffic_lights_cmd_master
//
// Accepts a host request (RECONFIG / OFF / ON) and turns it into a timed
// sequence of one-cycle command strobes for a traffic-light controller.
// Consecutive strobes are separated by CMD_GAP idle cycles, and the last
// strobe is also followed by CMD_GAP idle cycles before the next request
// can be taken.
//
// Ports
//   clk_i         clock, all logic on posedge
//   rst_n_i       asynchronous active-low reset
//   cfg_valid_i   host request valid
//   cfg_ready_o   request can be accepted (IDLE only, 0 while in reset)
//   cfg_op_i      0 RECONFIG, 1 OFF, 2 ON, 3 reserved
//   cfg_red_i     requested red period (clock cycles)
//   cfg_yellow_i  requested yellow period (clock cycles)
//   cfg_green_i   requested green period (clock cycles)
//   cmd_type_o    ON=0 OFF=1 TO_NOTRANSITION=2 GREEN_SET=3 RED_SET=4 YELLOW_SET=5
//   cmd_valid_o   one-cycle command strobe (consumer has no back-pressure)
//   cmd_data_o    command payload, 0 whenever cmd_valid_o is 0
//   busy_o        a sequence is in progress
//   err_o         one-cycle pulse for a rejected request
// -----------------------------------------------------------------------------
module traffic_lights_cmd_master #(
   parameter int unsigned CMD_GAP = 1,
   parameter int unsigned DATA_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [1:0]        cfg_op_i,
   input  logic [DATA_W-1:0] cfg_red_i,
   input  logic [DATA_W-1:0] cfg_yellow_i,
   input  logic [DATA_W-1:0] cfg_green_i,
   output logic [2:0]        cmd_type_o,
   output logic              cmd_valid_o,
   output logic [DATA_W-1:0] cmd_data_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam logic [1:0] OP_RECONFIG = 2'd0;
   localparam logic [1:0] OP_OFF      = 2'd1;
   localparam logic [1:0] OP_ON       = 2'd2;

   localparam logic [2:0] CMD_ON     = 3'd0;
   localparam logic [2:0] CMD_OFF    = 3'd1;
   localparam logic [2:0] CMD_NOTR   = 3'd2;
   localparam logic [2:0] CMD_GREEN  = 3'd3;
   localparam logic [2:0] CMD_RED    = 3'd4;
   localparam logic [2:0] CMD_YELLOW = 3'd5;

   // The counter counts down to zero inclusive, so it is loaded with CMD_GAP-1.
   localparam int unsigned GAP_LOAD_INT = (CMD_GAP == 0) ? 0 : CMD_GAP - 1;
   localparam logic [7:0]  GAP_LOAD     = 8'(GAP_LOAD_INT);

   typedef enum logic [2:0] {
      IDLE,
      S_NOTR,
      S_GREEN,
      S_RED,
      S_YELLOW,
      S_ON,
      S_OFF,
      GAP
   } state_e;

   state_e              state_q, state_d;
   state_e              ret_q, ret_d;     // state to resume after GAP
   state_e              succ;             // successor of the current S_* state
   logic [7:0]          gap_q, gap_d;
   logic                err_q, err_d;
   logic                ready_en_q;       // holds ready low until the first edge after reset
   logic [DATA_W-1:0]   red_q, yellow_q, green_q;
   logic                accept;
   logic                bad_period;

   assign cfg_ready_o = ready_en_q && (state_q == IDLE);
   assign busy_o      = ready_en_q && (state_q != IDLE);
   assign err_o       = err_q;
   assign accept      = cfg_valid_i && cfg_ready_o;
   assign bad_period  = (cfg_red_i == '0) || (cfg_yellow_i == '0) || (cfg_green_i == '0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         ret_q      <= IDLE;
         gap_q      <= 8'd0;
         err_q      <= 1'b0;
         ready_en_q <= 1'b0;
         red_q      <= '0;
         yellow_q   <= '0;
         green_q    <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         gap_q      <= gap_d;
         err_q      <= err_d;
         ready_en_q <= 1'b1;
         // Periods are only sampled on acceptance, so they stay frozen while busy.
         if (accept) begin
            red_q    <= cfg_red_i;
            yellow_q <= cfg_yellow_i;
            green_q  <= cfg_green_i;
         end
      end
   end

   // Command order inside a sequence; S_ON and S_OFF always end a sequence.
   always_comb begin
      succ = IDLE;
      case (state_q)
         S_NOTR:   succ = S_GREEN;
         S_GREEN:  succ = S_RED;
         S_RED:    succ = S_YELLOW;
         S_YELLOW: succ = S_ON;
         default:  succ = IDLE;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      gap_d   = gap_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cfg_op_i)
                  OP_RECONFIG: begin
                     if (bad_period) err_d   = 1'b1;
                     else            state_d = S_NOTR;
                  end
                  OP_OFF:  state_d = S_OFF;
                  OP_ON:   state_d = S_ON;
                  default: err_d   = 1'b1;
               endcase
            end
         end
         GAP: begin
            if (gap_q == 8'd0) state_d = ret_q;
            else               gap_d   = gap_q - 8'd1;
         end
         default: begin
            // Every S_* state lasts one cycle, then either gaps or moves on directly.
            if (CMD_GAP == 0) begin
               state_d = succ;
            end else begin
               state_d = GAP;
               ret_d   = succ;
               gap_d   = GAP_LOAD;
            end
         end
      endcase
   end

   always_comb begin
      cmd_valid_o = 1'b0;
      cmd_type_o  = 3'd0;
      cmd_data_o  = '0;
      case (state_q)
         S_NOTR: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_NOTR;
         end
         S_GREEN: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_GREEN;
            cmd_data_o  = green_q;
         end
         S_RED: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_RED;
            cmd_data_o  = red_q;
         end
         S_YELLOW: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_YELLOW;
            cmd_data_o  = yellow_q;
         end
         S_ON: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_ON;
         end
         S_OFF: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = CMD_OFF;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_lights_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_traffic_lights_cmd_master
//
// Three instances share one set of request inputs and differ only in CMD_GAP
// (1, 0 and 2). Each instance has its own reference model: an accepted
// request becomes a list of commands, and the expected output in any later
// cycle follows from the cycle count since acceptance by plain arithmetic
// (one strobe, then CMD_GAP quiet cycles, per command).
// -----------------------------------------------------------------------------
module tb_traffic_lights_cmd_master;

   localparam int NI = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic [1:0]    cfg_op;
   logic [DW-1:0] cfg_red, cfg_yellow, cfg_green;

   logic          cfg_ready [NI];
   logic [2:0]    cmd_type  [NI];
   logic          cmd_valid [NI];
   logic [DW-1:0] cmd_data  [NI];
   logic          busy      [NI];
   logic          err       [NI];

   always #5 clk = ~clk;

   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 2;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         traffic_lights_cmd_master #(
            .CMD_GAP((gi == 0) ? 1 : (gi == 1) ? 0 : 2),
            .DATA_W (DW)
         ) dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .cfg_valid_i (cfg_valid),
            .cfg_ready_o (cfg_ready[gi]),
            .cfg_op_i    (cfg_op),
            .cfg_red_i   (cfg_red),
            .cfg_yellow_i(cfg_yellow),
            .cfg_green_i (cfg_green),
            .cmd_type_o  (cmd_type[gi]),
            .cmd_valid_o (cmd_valid[gi]),
            .cmd_data_o  (cmd_data[gi]),
            .busy_o      (busy[gi]),
            .err_o       (err[gi])
         );
      end
   endgenerate

   // Reference model state, one entry per instance.
   bit            active   [NI];
   int            age      [NI];   // 1 = first cycle after acceptance
   int            ncmd     [NI];
   logic [2:0]    mtype    [NI][5];
   logic [DW-1:0] mdata    [NI][5];
   bit            err_pend [NI];

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, inst, obs, expv, $time);
      end
   endtask

   // One clock cycle: drive the request, check every instance mid-cycle,
   // then advance each model past the coming edge.
   task automatic step(input logic v, input logic [1:0] op,
                       input logic [DW-1:0] r, input logic [DW-1:0] y, input logic [DW-1:0] g);
      @(posedge clk);
      #1;
      cfg_valid  = v;
      cfg_op     = op;
      cfg_red    = r;
      cfg_yellow = y;
      cfg_green  = g;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         int            per;
         int            k;
         logic          ev;
         logic [2:0]    et;
         logic [DW-1:0] ed;
         logic          erdy;
         per  = gap_of(i) + 1;
         erdy = !active[i];
         ev   = 1'b0;
         et   = 3'd0;
         ed   = '0;
         if (active[i]) begin
            k = age[i] - 1;
            if (k % per == 0) begin
               ev = 1'b1;
               et = mtype[i][k / per];
               ed = mdata[i][k / per];
            end
         end
         chk("cfg_ready", i, 32'(cfg_ready[i]), 32'(erdy));
         chk("busy",      i, 32'(busy[i]),      32'(!erdy));
         chk("cmd_valid", i, 32'(cmd_valid[i]), 32'(ev));
         chk("cmd_type",  i, 32'(cmd_type[i]),  32'(et));
         chk("cmd_data",  i, 32'(cmd_data[i]),  32'(ed));
         chk("err",       i, 32'(err[i]),       32'(err_pend[i]));

         err_pend[i] = 1'b0;
         if (active[i]) begin
            age[i]++;
            if (age[i] > ncmd[i] * per) active[i] = 1'b0;
         end else if (v) begin
            $display("txn inst=%0d op=%0d red=%0d yellow=%0d green=%0d t=%0t", i, op, r, y, g, $time);
            case (op)
               2'd0: begin
                  if (r == '0 || y == '0 || g == '0) begin
                     err_pend[i] = 1'b1;
                  end else begin
                     ncmd[i] = 5;
                     mtype[i][0] = 3'd2; mdata[i][0] = '0;
                     mtype[i][1] = 3'd3; mdata[i][1] = g;
                     mtype[i][2] = 3'd4; mdata[i][2] = r;
                     mtype[i][3] = 3'd5; mdata[i][3] = y;
                     mtype[i][4] = 3'd0; mdata[i][4] = '0;
                     active[i] = 1'b1;
                     age[i]    = 1;
                  end
               end
               2'd1: begin
                  ncmd[i] = 1; mtype[i][0] = 3'd1; mdata[i][0] = '0;
                  active[i] = 1'b1; age[i] = 1;
               end
               2'd2: begin
                  ncmd[i] = 1; mtype[i][0] = 3'd0; mdata[i][0] = '0;
                  active[i] = 1'b1; age[i] = 1;
               end
               default: err_pend[i] = 1'b1;
            endcase
         end
      end
   endtask

   // Assert reset shortly after an edge, check the outputs clear without
   // waiting for a clock, keep it low across one edge, then release it
   // mid-cycle. The next step() then sees the first edge after release.
   task automatic mid_reset();
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("rst_ready", i, 32'(cfg_ready[i]), 32'd0);
         chk("rst_busy",  i, 32'(busy[i]),      32'd0);
         chk("rst_valid", i, 32'(cmd_valid[i]), 32'd0);
         chk("rst_type",  i, 32'(cmd_type[i]),  32'd0);
         chk("rst_data",  i, 32'(cmd_data[i]),  32'd0);
         chk("rst_err",   i, 32'(err[i]),       32'd0);
         active[i]   = 1'b0;
         err_pend[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) chk("rel_ready", i, 32'(cfg_ready[i]), 32'd0);
      $display("txn reset released t=%0t", $time);
   endtask

   function automatic logic [DW-1:0] rand_period();
      return ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 65535));
   endfunction

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_op     = 2'd0;
      cfg_red    = '0;
      cfg_yellow = '0;
      cfg_green  = '0;
      mid_reset();

      // Reference RECONFIG sequence, then idle until every instance is ready.
      step(1'b1, 2'd0, 16'd20, 16'd6, 16'd15);
      repeat (16) step(1'b0, 2'd0, '0, '0, '0);

      // Zero yellow period: rejected with an error pulse.
      step(1'b1, 2'd0, 16'd20, 16'd0, 16'd15);
      repeat (3) step(1'b0, 2'd0, '0, '0, '0);

      // Reserved opcode.
      step(1'b1, 2'd3, 16'd5, 16'd5, 16'd5);
      repeat (2) step(1'b0, 2'd0, '0, '0, '0);

      // OFF, then ON held while busy.
      step(1'b1, 2'd1, '0, '0, '0);
      repeat (4) step(1'b1, 2'd2, '0, '0, '0);
      repeat (8) step(1'b0, 2'd0, '0, '0, '0);

      // Reset in the middle of a RECONFIG sequence.
      step(1'b1, 2'd0, 16'd20, 16'd6, 16'd15);
      repeat (3) step(1'b0, 2'd0, '0, '0, '0);
      mid_reset();
      repeat (12) step(1'b0, 2'd0, '0, '0, '0);

      // Random traffic with period fields changing while busy.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            mid_reset();
         end else begin
            logic       v;
            logic [1:0] op;
            v  = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            step(v, op, rand_period(), rand_period(), rand_period());
         end
      end
      repeat (16) step(1'b0, 2'd0, '0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
